// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial word adder/subtractor.
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sw_state_t;

  // Bit-counter width for a given word width (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Subtraction runs as a + ~b + ~borrow_in, so the borrow is inverted on entry.
  function automatic logic carry_init(input logic cin, input logic sub);
    return cin ^ sub;
  endfunction

endpackage

// File: rtl/full_add_bit.sv
// Combinational one-bit full adder used by the serial datapath.
module full_add_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_word_add.sv
// Bit-serial word adder/subtractor, LSB first, with parallel result at word end.
// Define SERIAL_WORD_ADD_SUB_EN to compile in the subtract path; otherwise sub_i is ignored.
module serial_word_add
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             cin_i,
  input  logic             sub_i,
  input  logic             in_valid_i,
  input  logic             a_bit_i,
  input  logic             b_bit_i,
  output logic             s_bit_o,
  output logic             s_valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  sw_state_t        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             s_bit_q, s_bit_d;
  logic             s_valid_q, s_valid_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             sub_q;
  logic             sub_start;
  logic             b_eff;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_WORD_ADD_SUB_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q <= 1'b0;
    end else if (state_q == StIdle && start_i) begin
      sub_q <= sub_i;
    end
  end

  assign sub_start = sub_i;
  assign b_eff     = b_bit_i ^ sub_q;
`else
  logic unused_sub;
  assign unused_sub = sub_i;
  assign sub_q      = 1'b0;
  assign sub_start  = 1'b0;
  assign b_eff      = b_bit_i;
`endif

  full_add_bit u_full_add_bit (
    .a_i  (a_bit_i),
    .b_i  (b_eff),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sr_d      = sr_q;
    sum_d     = sum_q;
    s_bit_d   = s_bit_q;
    s_valid_d = 1'b0;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          cnt_d   = '0;
          carry_d = carry_init(cin_i, sub_start);
        end
      end
      StRun: begin
        if (in_valid_i) begin
          s_bit_d   = fa_s;
          s_valid_d = 1'b1;
          carry_d   = fa_co;
          // Sum bits enter at the MSB end so the LSB lands at bit 0 after WIDTH shifts.
          sr_d      = {fa_s, sr_q[WIDTH-1:1]};
          if (cnt_q == LastIdx) begin
            state_d = StDone;
            sum_d   = {fa_s, sr_q[WIDTH-1:1]};
            cout_d  = fa_co ^ sub_q;
            ovf_d   = carry_q ^ fa_co;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      sr_q      <= '0;
      sum_q     <= '0;
      s_bit_q   <= 1'b0;
      s_valid_q <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      sr_q      <= sr_d;
      sum_q     <= sum_d;
      s_bit_q   <= s_bit_d;
      s_valid_q <= s_valid_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign s_bit_o   = s_bit_q;
  assign s_valid_o = s_valid_q;
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign ovf_o     = ovf_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_serial_word_add.sv
// Self-checking bench for serial_word_add: directed words plus random words with stalls.
module tb_serial_word_add;

  localparam int unsigned W = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic         cin_i;
  logic         sub_i;
  logic         in_valid_i;
  logic         a_bit_i;
  logic         b_bit_i;
  logic         s_bit_o;
  logic         s_valid_o;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         ovf_o;
  logic         done_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] got_sum;
  logic         got_cout;
  logic         got_ovf;

  serial_word_add #(
    .WIDTH (W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .cin_i      (cin_i),
    .sub_i      (sub_i),
    .in_valid_i (in_valid_i),
    .a_bit_i    (a_bit_i),
    .b_bit_i    (b_bit_i),
    .s_bit_o    (s_bit_o),
    .s_valid_o  (s_valid_o),
    .sum_o      (sum_o),
    .cout_o     (cout_o),
    .ovf_o      (ovf_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Word-level reference: integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, output logic [W-1:0] s, output logic co,
                                output logic ov);
    longint ua, ub, sa, sb, c, r, sr, smax, smin;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    c    = cin ? 64'sd1 : 64'sd0;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
`ifdef SERIAL_WORD_ADD_SUB_EN
    if (sub) begin
      r  = ua - ub - c;
      sr = sa - sb - c;
      co = (r < 0);
    end else
`endif
    begin
      r  = ua + ub + c;
      sr = sa + sb + c;
      co = (r >= (longint'(1) << W));
    end
    s  = r[W-1:0];
    ov = (sr > smax) || (sr < smin);
  endfunction

  // One word: optional stall burst before slot stall_at, optional start pokes in RUN and DONE.
  task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int stall_at, input int stall_len,
                          input bit poke_start);
    logic [W-1:0] es;
    logic         ec, eo, v;
    int           nslots, bit_i;
    model(a, b, cin, sub, es, ec, eo);
    start_i    = 1'b1;
    cin_i      = cin;
    sub_i      = sub;
    in_valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", W'(busy_o), W'(1'b1));
    nslots = W + stall_len;
    bit_i  = 0;
    for (int k = 0; k < nslots; k++) begin
      v          = !(k >= stall_at && k < stall_at + stall_len);
      in_valid_i = v;
      a_bit_i    = v ? a[bit_i] : 1'($urandom);
      b_bit_i    = v ? b[bit_i] : 1'($urandom);
      start_i    = poke_start && (k == 1);
      tick();
      start_i = 1'b0;
      chk("s_valid", W'(s_valid_o), W'(v));
      if (v) begin
        chk("s_bit", W'(s_bit_o), W'(es[bit_i]));
        bit_i++;
      end
      chk("done_pulse", W'(done_o), W'(k == nslots - 1));
    end
    in_valid_i = 1'b0;
    chk("busy_in_done", W'(busy_o), W'(1'b1));
    chk("sum", sum_o, es);
    chk("cout", W'(cout_o), W'(ec));
    chk("ovf", W'(ovf_o), W'(eo));
    got_sum  = sum_o;
    got_cout = cout_o;
    got_ovf  = ovf_o;
    start_i  = poke_start;
    tick();
    start_i = 1'b0;
    chk("idle_after_done", W'(busy_o), W'(1'b0));
    chk("done_cleared", W'(done_o), W'(1'b0));
    chk("sum_hold", sum_o, es);
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    cin_i      = 1'b0;
    sub_i      = 1'b0;
    in_valid_i = 1'b0;
    a_bit_i    = 1'b0;
    b_bit_i    = 1'b0;
    tick();
    tick();
    chk("rst_busy", W'(busy_o), W'(1'b0));
    chk("rst_sum", sum_o, W'(0));
    chk("rst_done", W'(done_o), W'(1'b0));
    chk("rst_s_valid", W'(s_valid_o), W'(1'b0));
    chk("rst_cout_ovf", W'({cout_o, ovf_o, s_bit_o}), W'(0));
    rst_ni = 1'b1;
    tick();

    run_word(8'h5A, 8'h33, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("dir_5a33_sum", got_sum, 8'h8D);
    chk("dir_5a33_cout", W'(got_cout), W'(1'b0));
    chk("dir_5a33_ovf", W'(got_ovf), W'(1'b1));

    run_word(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("dir_ff01_sum", got_sum, 8'h00);
    chk("dir_ff01_cout", W'(got_cout), W'(1'b1));
    chk("dir_ff01_ovf", W'(got_ovf), W'(1'b0));
    run_word(8'h00, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("dir_chain_sum", got_sum, 8'h01);

`ifdef SERIAL_WORD_ADD_SUB_EN
    run_word(8'h10, 8'h20, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("dir_sub1_sum", got_sum, 8'hF0);
    chk("dir_sub1_borrow", W'(got_cout), W'(1'b1));
    chk("dir_sub1_ovf", W'(got_ovf), W'(1'b0));
    run_word(8'h80, 8'h01, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("dir_sub2_sum", got_sum, 8'h7F);
    chk("dir_sub2_ovf", W'(got_ovf), W'(1'b1));
`else
    run_word(8'h10, 8'h20, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("dir_nosub_sum", got_sum, 8'h30);
    chk("dir_nosub_cout", W'(got_cout), W'(1'b0));
`endif

    // Three stall cycles mid-word plus start pokes in RUN and DONE.
    run_word(8'h5A, 8'h33, 1'b0, 1'b0, 4, 3, 1'b1);
    chk("dir_stall_sum", got_sum, 8'h8D);
    chk("dir_stall_ovf", W'(got_ovf), W'(1'b1));

    // Abort a word with reset after three accepted bits.
    start_i = 1'b1;
    cin_i   = 1'b0;
    sub_i   = 1'b0;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 1'b1;
      a_bit_i    = 1'b1;
      b_bit_i    = 1'b0;
      tick();
    end
    in_valid_i = 1'b0;
    rst_ni     = 1'b0;
    #1;
    chk("abort_busy", W'(busy_o), W'(1'b0));
    chk("abort_sum", sum_o, W'(0));
    chk("abort_done", W'(done_o), W'(1'b0));
    chk("abort_flags", W'({s_valid_o, s_bit_o, cout_o, ovf_o}), W'(0));
    tick();
    rst_ni = 1'b1;
    tick();
    chk("abort_no_done", W'(done_o), W'(1'b0));
    chk("abort_idle", W'(busy_o), W'(1'b0));
    run_word(8'h01, 8'h01, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("after_abort_sum", got_sum, 8'h02);

    for (int n = 0; n < 24; n++) begin
      run_word(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, W - 1)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_add.md
# serial_word_add

Parametrised bit-serial word adder/subtractor: consumes two operands LSB-first, one bit per accepted cycle, under a valid handshake. Emits each sum bit serially and, at word end, a deserialised parallel sum with carry/borrow-out and signed overflow. Sits between serial operand sources and parallel consumers; `cin`/`cout` chain words for multi-word arithmetic.

## Interface
- `WIDTH`, 8: bits per word; legal values are WIDTH ≥ 2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a word; sampled only in IDLE.
- `cin`  in  1  carry-in (add) or borrow-in (sub); sampled with `start`.
- `sub`  in  1  1 = compute a − b; sampled with `start`.
- `in_valid`  in  1  `a_bit`/`b_bit` valid this cycle.
- `a_bit`, `b_bit`  in  1 each  operand bits, LSB first.
- `s_bit`  out  1  registered sum bit.
- `s_valid`  out  1  `s_bit` valid this cycle.
- `sum`  out  WIDTH  parallel result; updated at `done`.
- `cout`  out  1  carry-out (add) or borrow-out (sub); updated at `done`.
- `ovf`  out  1  two's-complement overflow; updated at `done`.
- `done`  out  1  one-cycle pulse: word complete.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE when bit WIDTH−1 is accepted.
  - DONE → IDLE unconditionally after one cycle.
- On start: bit counter cleared; `sub` latched.
  - Carry register loaded with `cin` (add) or `~cin` (sub).
- Subtract: b bit inverted before the full adder. a − b − borrow_in ≡ a + ~b + ~borrow_in.
- RUN, `in_valid`=1: a bit is accepted.
  - s = a ^ b' ^ c; c ← maj(a, b', c).
  - s shifted into the sum shift register from the MSB end; counter increments.
- RUN, `in_valid`=0: stall; carry, counter and shift register hold.
- At the MSB (counter = WIDTH−1):
  - carry into the MSB is captured.
  - `ovf` = carry_into_MSB ^ carry_out.
  - `cout` = carry_out (add) or ~carry_out (sub, borrow).
- `in_valid` ignored outside RUN. `start` ignored outside IDLE, including in DONE.
- `sum`, `cout`, `ovf` hold between `done` pulses.
- Counter width is $clog2(WIDTH). No wrap occurs: the FSM leaves RUN at WIDTH−1.

## Timing
- Reset (async assert, synchronous-release usage): state IDLE; all outputs 0 (`s_bit`, `s_valid`, `sum`, `cout`, `ovf`, `done`, `busy`); carry and counter 0.
- Reset mid-word aborts the word. No partial `done`, and `sum` is not updated.
- `start` at cycle T0 → `busy`=1 from T0+1. The first bit may be accepted at T0+1.
- A bit accepted at cycle T appears as `s_bit`/`s_valid`=1 at T+1 (1-cycle latency).
- MSB accepted at Tn → at Tn+1:
  - last `s_valid`=1 and `done`=1 together;
  - `sum`/`cout`/`ovf` are valid in the same cycle.
  - Also at Tn+1: state is DONE.
- At Tn+2: IDLE, `busy`=0; earliest new `start` is accepted here.
- Unstalled word: `done` at T0+WIDTH+1. Each stall cycle adds one cycle.

## Configuration
- `SERIAL_WORD_ADD_SUB_EN` defined: subtract path compiled in; `sub` behaves as above.
- Undefined: `sub` port is still present but ignored (treated as 0). `cin` is always carry-in, and there is no b inversion logic.

## Structure
- Package `serial_add_pkg`:
  - state typedef `sw_state_t` (IDLE/RUN/DONE);
  - `localparam` helper for counter width;
  - carry-init function.
- Sub-module `full_add_bit`: combinational 1-bit full adder (a, b, c → s, co). It is instantiated once; the carry register lives in the parent.

## Test plan
- WIDTH=8, add 0x5A + 0x33, cin=0, no stalls → `sum`=0x8D, `cout`=0, `ovf`=1, `done` at T0+9, `s_bit` stream 1,0,1,1,0,0,0,1.
- Add 0xFF + 0x01, cin=0 → `sum`=0x00, `cout`=1, `ovf`=0. Then chained word 0x00 + 0x00 with cin=1 → `sum`=0x01.
- SUB_EN defined: 0x10 − 0x20, cin=0 → `sum`=0xF0, `cout`(borrow)=1, `ovf`=0. 0x80 − 0x01 → `sum`=0x7F, `ovf`=1.
- 0x5A + 0x33 with `in_valid` deasserted for 3 cycles mid-word → same results, `done` at T0+12; `start` pulsed during RUN and DONE is ignored.
- Assert `reset_n`=0 after 3 accepted bits → all outputs 0, `busy`=0, no `done`. Next word 0x01 + 0x01 → `sum`=0x02.
- SUB_EN undefined: `sub`=1 with 0x10, 0x20 → `sum`=0x30, `cout`=0.
